// File: rtl/res_blockser_if.sv
// Handshake bundle for res_blockser: macroblock capture port and 4x4-block output stream.
// The slave modport is the serialiser's view; master is the upstream/downstream environment.
interface res_blockser_if #(
   parameter int unsigned RES_W   = 8,
   parameter int unsigned MBNUM_W = 32
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [MBNUM_W-1:0]   in_mbnumber;
   logic [2:0]           in_mode_luma;
   logic [2:0]           in_mode_cb;
   logic [2:0]           in_mode_cr;
   logic [256*RES_W-1:0] in_res_luma;
   logic [64*RES_W-1:0]  in_res_cb;
   logic [64*RES_W-1:0]  in_res_cr;

   logic                 out_valid;
   logic                 out_ready;
   logic [16*RES_W-1:0]  out_blk;
   logic [1:0]           out_comp;
   logic [3:0]           out_blkidx;
   logic [2:0]           out_mode;
   logic                 out_nz;
   logic [MBNUM_W-1:0]   out_mbnumber;
   logic                 out_last;

   modport slave (
      input  in_valid, in_mbnumber, in_mode_luma, in_mode_cb, in_mode_cr,
      input  in_res_luma, in_res_cb, in_res_cr, out_ready,
      output in_ready, out_valid, out_blk, out_comp, out_blkidx, out_mode, out_nz,
      output out_mbnumber, out_last
   );

   modport master (
      output in_valid, in_mbnumber, in_mode_luma, in_mode_cb, in_mode_cr,
      output in_res_luma, in_res_cb, in_res_cr, out_ready,
      input  in_ready, out_valid, out_blk, out_comp, out_blkidx, out_mode, out_nz,
      input  out_mbnumber, out_last
   );
endinterface

// File: rtl/res_blockser.sv
// Captures one macroblock of luma/Cb/Cr residues and streams it as 24 registered 4x4 beats
// (16 luma, 4 Cb, 4 Cr) over a valid/ready handshake.
module res_blockser #(
   parameter int unsigned RES_W   = 8,
   parameter int unsigned MBNUM_W = 32
) (
   input logic           clk,
   input logic           reset,
   res_blockser_if.slave io
);
   localparam int unsigned LumaW   = 256 * RES_W;
   localparam int unsigned ChromaW = 64 * RES_W;
   localparam int unsigned BlkW    = 16 * RES_W;

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   state_e             state_q;
   logic [4:0]         cnt_q;
   logic [LumaW-1:0]   luma_q;
   logic [ChromaW-1:0] cb_q;
   logic [ChromaW-1:0] cr_q;
   logic [2:0]         mode_luma_q;
   logic [2:0]         mode_cb_q;
   logic [2:0]         mode_cr_q;

   logic [4:0]         nxt_cnt;
   logic [LumaW-1:0]   src_luma;
   logic [ChromaW-1:0] src_chroma;
   logic [BlkW-1:0]    luma_blk;
   logic [BlkW-1:0]    chroma_blk;
   logic [BlkW-1:0]    nxt_blk;
   logic [1:0]         nxt_comp;
   logic [3:0]         nxt_blkidx;
   logic [2:0]         nxt_mode;
   int unsigned        lby, lbx, cby, cbx;

   // Next beat is beat 0 straight from the inputs when capturing, else cnt+1 from the buffer.
   always_comb begin
      nxt_cnt    = (state_q == StIdle) ? 5'd0 : cnt_q + 5'd1;
      src_luma   = (state_q == StIdle) ? io.in_res_luma : luma_q;
      src_chroma = (nxt_cnt >= 5'd20) ? cr_q : cb_q;
      lby        = 32'(nxt_cnt[3:2]);
      lbx        = 32'(nxt_cnt[1:0]);
      cby        = 32'(nxt_cnt[1]);
      cbx        = 32'(nxt_cnt[0]);
      luma_blk   = '0;
      chroma_blk = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            luma_blk[RES_W*(4*r+c) +: RES_W] =
               src_luma[RES_W*((4*lby+r)*16 + 4*lbx + c) +: RES_W];
            chroma_blk[RES_W*(4*r+c) +: RES_W] =
               src_chroma[RES_W*((4*cby+r)*8 + 4*cbx + c) +: RES_W];
         end
      end
      if (nxt_cnt < 5'd16) begin
         nxt_comp   = 2'd0;
         nxt_blkidx = nxt_cnt[3:0];
         nxt_mode   = (state_q == StIdle) ? io.in_mode_luma : mode_luma_q;
         nxt_blk    = luma_blk;
      end else begin
         // Chroma beats 16..19 and 20..23 both have their block index in the low two bits.
         nxt_comp   = (nxt_cnt < 5'd20) ? 2'd1 : 2'd2;
         nxt_blkidx = {2'b00, nxt_cnt[1:0]};
         nxt_mode   = (nxt_cnt < 5'd20) ? mode_cb_q : mode_cr_q;
         nxt_blk    = chroma_blk;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == StIdle && io.in_valid) begin
         luma_q      <= io.in_res_luma;
         cb_q        <= io.in_res_cb;
         cr_q        <= io.in_res_cr;
         mode_luma_q <= io.in_mode_luma;
         mode_cb_q   <= io.in_mode_cb;
         mode_cr_q   <= io.in_mode_cr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= StIdle;
         cnt_q           <= 5'd0;
         io.in_ready     <= 1'b1;
         io.out_valid    <= 1'b0;
         io.out_blk      <= '0;
         io.out_comp     <= 2'd0;
         io.out_blkidx   <= 4'd0;
         io.out_mode     <= 3'd0;
         io.out_nz       <= 1'b0;
         io.out_mbnumber <= '0;
         io.out_last     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (io.in_valid) begin
                  state_q         <= StStream;
                  cnt_q           <= 5'd0;
                  io.in_ready     <= 1'b0;
                  io.out_valid    <= 1'b1;
                  io.out_blk      <= nxt_blk;
                  io.out_comp     <= nxt_comp;
                  io.out_blkidx   <= nxt_blkidx;
                  io.out_mode     <= nxt_mode;
                  io.out_nz       <= |nxt_blk;
                  io.out_mbnumber <= io.in_mbnumber;
                  io.out_last     <= 1'b0;
               end
            end
            StStream: begin
               if (io.out_ready) begin
                  if (cnt_q == 5'd23) begin
                     state_q      <= StIdle;
                     cnt_q        <= 5'd0;
                     io.in_ready  <= 1'b1;
                     io.out_valid <= 1'b0;
                     io.out_last  <= 1'b0;
                  end else begin
                     cnt_q         <= nxt_cnt;
                     io.out_blk    <= nxt_blk;
                     io.out_comp   <= nxt_comp;
                     io.out_blkidx <= nxt_blkidx;
                     io.out_mode   <= nxt_mode;
                     io.out_nz     <= |nxt_blk;
                     io.out_last   <= (nxt_cnt == 5'd23);
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: doc/res_blockser.md
Name: res_blockser

Overview:
- Downstream of the intra-prediction stage. Captures one macroblock's chosen residuals: luma 16x16 plus the Cb and Cr 8x8 blocks, with their mode numbers.
- Serialises them as 4x4 residual blocks to the integer-transform stage over a valid/ready handshake.
- Converts the wide parallel result into a narrow per-block stream and decouples intra-prediction timing from transform backpressure.

Parameters:
RES_W, 8, bit width of one signed residue
MBNUM_W, 32, width of the macroblock number tag

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  upstream macroblock result valid
in_ready  out  1  block can capture a macroblock this cycle
in_mbnumber  in  MBNUM_W  macroblock number of the incoming result
in_mode_luma  in  3  chosen luma 16x16 mode
in_mode_cb  in  3  chosen Cb 8x8 mode
in_mode_cr  in  3  chosen Cr 8x8 mode
in_res_luma  in  256*RES_W  luma residues, element k at [RES_W*k +: RES_W], raster k=row*16+col
in_res_cb  in  64*RES_W  Cb residues, raster k=row*8+col
in_res_cr  in  64*RES_W  Cr residues, raster k=row*8+col
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_blk  out  16*RES_W  one 4x4 block, element j at [RES_W*j +: RES_W], j=r*4+c
out_comp  out  2  0=luma, 1=Cb, 2=Cr
out_blkidx  out  4  block index within its component
out_mode  out  3  mode of the component being sent
out_nz  out  1  1 if any element of out_blk is nonzero
out_mbnumber  out  MBNUM_W  tag of the macroblock being sent
out_last  out  1  final beat of the macroblock

Behaviour:
- States: IDLE, STREAM. Beat counter cnt, 0..23.
- Reset (reset=0, asynchronous): state=IDLE, cnt=0. in_ready=1 from the first cycle after release. All other outputs 0. Capture buffer contents don't care.
- Reset mid-stream: the beat in flight is abandoned with no completion. After release the block is in IDLE.
- Reset behaviour repeated as outputs: reset values are in_ready=1 and every other output 0.
- in_ready = (state==IDLE), driven from a register.
- IDLE:
  - on in_valid=1, capture all in_* into internal buffer; state→STREAM; cnt=0.
  - out_valid rises the next cycle (capture-to-first-beat latency = 1 cycle).
- Beat order (24 beats):
  - cnt 0..15: luma, blkidx=cnt, by=cnt[3:2], bx=cnt[1:0].
  - cnt 16..19: Cb, blkidx=cnt-16, by=blkidx[1], bx=blkidx[0].
  - cnt 20..23: Cr, blkidx=cnt-20, same mapping as Cb.
- Element mapping:
  - luma: out_blk[j] = luma[(4*by+r)*16 + 4*bx + c].
  - chroma: out_blk[j] = chroma[(4*by+r)*8 + 4*bx + c].
  - Sign bits copied unchanged; no arithmetic on residues.
- out_mode = mode of the current component. out_mbnumber = captured tag.
- out_last = 1 only at cnt==23.
- out_nz = OR-reduction of the 16 elements of the current beat.
- STREAM:
  - Beat completes when out_valid && out_ready; cnt increments.
  - If out_ready=0, every out_* holds bit-stable.
  - When cnt==23 completes: state→IDLE, out_valid=0 and in_ready=1 on the next cycle.
- Input changes and in_valid while in STREAM are ignored; the buffer is written only on a capture in IDLE.
- Throughput: minimum 25 cycles per macroblock (1 capture + 24 beats).
- All outputs registered; no combinational path from out_ready to out_valid or out_blk.

Test Plan:
1. Reset: drive reset=0 during beat 7 of a stream → out_valid=0 and all out_*=0 immediately. After release, in_ready=1; the next macroblock starts at cnt=0.
2. Ordering: luma[k]=k[7:0], Cb all 0, Cr[k]=-k, in_mbnumber=0x2A, out_ready=1.
   - Beat 5 out_blk[0]=68, out_blkidx=5.
   - Beat 15 out_blk[15]=8'hFF (index 255).
   - Beats 16..19 out_nz=0.
   - Beat 23 out_blk[15]=-63, out_last=1.
   - Every beat out_mbnumber=0x2A.
3. Backpressure: out_ready toggles 1,0,1,0 → 24 beats in the same order over 48 cycles. Data stable on every stalled cycle; in_ready=0 throughout.
4. Back-to-back: in_valid held 1 with tags 1 and 2 → tag 2 captured exactly 1 cycle after tag 1's out_last handshake. Its first beat appears the following cycle.
5. Input isolation: change in_res_luma and in_mbnumber every cycle during STREAM → outputs match the captured macroblock only.
6. Modes: luma=2, cb=1, cr=0 → out_mode 2 on beats 0..15, 1 on beats 16..19, 0 on beats 20..23.
